uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Parametrised full-duplex UART with programmable data width, fixed-divisor baud tick generation, 16x oversampled receiver and transmit/receive FIFOs with valid/ready handshakes. It replaces the single-word UART front end between the serial pins and the ALU command interface. Line errors (framing, overrun, optional parity) are flagged per word.

## Interface
- `NB_DATA`, 8: data bits per frame (5..9).
- `BAUD_DIV`, 163: clock cycles per oversample tick (16 ticks per bit); ≥2.
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, ≥2.

- `i_clock` in 1: single clock; all logic rising-edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_rx` in 1: serial input, asynchronous to `i_clock`.
- `o_tx` out 1: serial output, idle high.
- `i_tx_data` in NB_DATA: word to transmit.
- `i_tx_valid` in 1: push request into TX FIFO.
- `o_tx_ready` out 1: TX FIFO not full.
- `o_tx_done_tick` out 1: one-cycle pulse at end of each stop bit.
- `o_rx_data` out NB_DATA: head of RX FIFO (first-word fall-through).
- `o_rx_valid` out 1: RX FIFO not empty.
- `i_rx_ready` in 1: consumer pop.
- `o_rx_frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `o_rx_overrun` out 1: one-cycle pulse, received word dropped on full RX FIFO.
- `o_rx_parity_err` out 1: one-cycle pulse, parity mismatch.

## Operation
- Reset: `o_tx`=1, `o_tx_ready`=1, `o_rx_valid`=0, `o_rx_data`=0, all pulses 0, FIFOs empty, both FSMs IDLE, baud counter 0.
- Baud gen: counter 0..BAUD_DIV-1; tick is a one-cycle pulse when counter = BAUD_DIV-1, then wraps to 0. Free-running.
- `i_rx` passes a 2-flop synchroniser; the RX FSM sees only the synchronised value.
- RX FSM IDLE→START→DATA→[PARITY]→STOP→IDLE. IDLE: synced low → START, tick count cleared. START: at 8th tick, low → DATA; high → IDLE (glitch, no flag). DATA: sample every 16 ticks, LSB first, NB_DATA bits. STOP: sample at 16th tick; high → push word; low → `o_rx_frame_err`, word discarded. Always back to IDLE.
- RX push with FIFO full and no same-cycle pop → word dropped, `o_rx_overrun` pulses. Push and pop in the same cycle on a full FIFO: both succeed, no overrun.
- RX pop: `o_rx_valid && i_rx_ready`; next entry appears the following cycle.
- TX push: `i_tx_valid && o_tx_ready`; pushes while full are ignored, with no side effects.
- TX FSM IDLE→START→DATA→[PARITY]→STOP→IDLE. IDLE with non-empty FIFO: pop into shift register, go to START. Each bit is held 16 ticks, LSB first. Stop bit is 1. `o_tx_done_tick` pulses on the cycle STOP ends. Back-to-back words have no idle gap when the FIFO is non-empty.
- `o_tx` is registered and glitch-free.
- Pointer/count arithmetic is modulo 2·FIFO_DEPTH. Full = count FIFO_DEPTH; empty = count 0.

## Timing
- TX: word pushed into empty TX FIFO in cycle N → popped N+1 → `o_tx` low at N+2.
- Start bit is 16 ticks counted from the first tick after entering START, i.e. up to BAUD_DIV-1 cycles longer. All later bits are exactly 16·BAUD_DIV cycles.
- RX: `o_rx_valid` rises one cycle after the tick that samples the stop bit. Error pulses occur on the same cycle.
- Synchroniser adds 2 cycles of input latency.
- `o_tx_ready` deasserts the cycle after the push that fills the FIFO.
- Reset asserted mid-frame: `o_tx` returns to 1 immediately and asynchronously. The in-flight frame is aborted and FIFO contents are lost.

## Configuration
- `UART_PARITY_EN` defined: an even-parity bit is inserted after the data bits on TX (16 ticks). RX samples the parity bit; on mismatch it pulses `o_rx_parity_err` and discards the word. A stop-bit error takes precedence, reporting only `o_rx_frame_err`.
- Undefined: no PARITY state, frame is start + NB_DATA + stop, and `o_rx_parity_err` is tied 0.

## Test plan
All scenarios use BAUD_DIV=4, NB_DATA=8, FIFO_DEPTH=4, without parity, unless noted. One bit = 64 cycles.
- Reset check: assert `i_reset` mid-transmission → `o_tx`=1 the same cycle, `o_tx_ready`=1, `o_rx_valid`=0.
- TX order: push 0xA5, 0x3C back-to-back → on `o_tx`: 0 then bits 1,0,1,0,0,1,0,1, then 1, then immediately 0x3C's frame; exactly two `o_tx_done_tick` pulses.
- Loopback: tie `o_tx` to `i_rx`, push 0x00, 0xFF, 0x81, 0x7E → same four words appear in order on `o_rx_data`; no error pulses.
- Overrun and simultaneous push/pop: drive 5 frames with `i_rx_ready`=0 → FIFO holds the first 4 and one `o_rx_overrun` pulse occurs. Repeat while popping on the push cycle → no overrun.
- Errors: a 1-tick low glitch on `i_rx` → no word, no flag. A frame with stop bit 0 → `o_rx_frame_err` pulse, no word. With `UART_PARITY_EN`, send 0x01 with parity bit 0 → `o_rx_parity_err` pulse, no word.

Source files
------------

// File: rtl/uart_fifo_core.sv
`default_nettype none
// uart_fifo_core: full-duplex UART with 16x oversampled RX and TX/RX FIFOs (valid/ready).
// Optional even parity bit when UART_PARITY_EN is defined.  Rev 1.0
module uart_fifo_core #(
  parameter int NB_DATA    = 8,
  parameter int BAUD_DIV   = 163,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic               o_tx,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  output logic               o_tx_done_tick,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_valid,
  input  logic               i_rx_ready,
  output logic               o_rx_frame_err,
  output logic               o_rx_overrun,
  output logic               o_rx_parity_err
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = $clog2(BAUD_DIV);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  LAST_BIT = 4'(NB_DATA-1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [CW-1:0] baud_cnt;
  logic          tick;
  logic          rx_meta, rx_sync;

  assign tick = (baud_cnt == CW'(BAUD_DIV-1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      baud_cnt <= '0;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + CW'(1);
      rx_meta  <= i_rx;
      rx_sync  <= rx_meta;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [NB_DATA-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]        tx_wr, tx_rd, tx_count;
  logic [NB_DATA-1:0] tx_head;
  logic               tx_push, tx_pop;

  assign tx_count   = tx_wr - tx_rd;
  assign o_tx_ready = (tx_count != FULL_CNT);
  assign tx_push    = i_tx_valid && o_tx_ready;
  assign tx_head    = tx_mem[tx_rd[AW-1:0]];

  always_ff @(posedge i_clock) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= i_tx_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + (AW+1)'(1);
      if (tx_pop)  tx_rd <= tx_rd + (AW+1)'(1);
    end
  end

  // ---------------- TX FSM ----------------
  state_t             tx_state;
  logic [3:0]         tx_ticks, tx_bits;
  logic [NB_DATA-1:0] tx_shift;
  logic               tx_bit_end;
`ifdef UART_PARITY_EN
  logic               tx_par;
`endif

  assign tx_bit_end = tick && (tx_ticks == 4'd15);
  // STOP hands straight over to the next word so back-to-back frames have no gap.
  assign tx_pop = (tx_count != '0) &&
                  ((tx_state == IDLE) || ((tx_state == STOP) && tx_bit_end));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_state       <= IDLE;
      tx_ticks       <= '0;
      tx_bits        <= '0;
      tx_shift       <= '0;
      o_tx           <= 1'b1;
      o_tx_done_tick <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par         <= 1'b0;
`endif
    end else begin
      o_tx_done_tick <= 1'b0;
      if (tick && (tx_state != IDLE)) tx_ticks <= tx_ticks + 4'd1;
      case (tx_state)
        IDLE: if (tx_pop) begin
          tx_shift <= tx_head;
          tx_ticks <= '0;
          o_tx     <= 1'b0;
          tx_state <= START;
`ifdef UART_PARITY_EN
          tx_par   <= ^tx_head;
`endif
        end
        START: if (tx_bit_end) begin
          tx_bits  <= '0;
          o_tx     <= tx_shift[0];
          tx_state <= DATA;
        end
        DATA: if (tx_bit_end) begin
          if (tx_bits == LAST_BIT) begin
`ifdef UART_PARITY_EN
            o_tx     <= tx_par;
            tx_state <= PARITY;
`else
            o_tx     <= 1'b1;
            tx_state <= STOP;
`endif
          end else begin
            tx_bits  <= tx_bits + 4'd1;
            tx_shift <= tx_shift >> 1;
            o_tx     <= tx_shift[1];
          end
        end
`ifdef UART_PARITY_EN
        PARITY: if (tx_bit_end) begin
          o_tx     <= 1'b1;
          tx_state <= STOP;
        end
`endif
        STOP: if (tx_bit_end) begin
          o_tx_done_tick <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_head;
            o_tx     <= 1'b0;
            tx_state <= START;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
          end else begin
            tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  state_t             rx_state;
  logic [3:0]         rx_ticks, rx_bits;
  logic [NB_DATA-1:0] rx_shift;
  logic               rx_sample_stop, rx_par_ok, rx_push;
`ifdef UART_PARITY_EN
  logic               rx_par_bit;
  assign rx_par_ok = ~(^{rx_shift, rx_par_bit});
`else
  assign rx_par_ok = 1'b1;
`endif

  assign rx_sample_stop = (rx_state == STOP) && tick && (rx_ticks == 4'd15);
  assign rx_push        = rx_sample_stop && rx_sync && rx_par_ok;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_state <= IDLE;
      rx_ticks <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par_bit <= 1'b0;
`endif
    end else begin
      case (rx_state)
        IDLE: if (!rx_sync) begin
          rx_ticks <= '0;
          rx_state <= START;
        end
        // Mid-start re-check rejects short glitches without flagging anything.
        START: if (tick) begin
          if (rx_ticks == 4'd7) begin
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            rx_ticks <= rx_ticks + 4'd1;
          end
        end
        DATA: if (tick) begin
          rx_ticks <= rx_ticks + 4'd1;
          if (rx_ticks == 4'd15) begin
            rx_shift <= {rx_sync, rx_shift[NB_DATA-1:1]};
            rx_bits  <= rx_bits + 4'd1;
`ifdef UART_PARITY_EN
            if (rx_bits == LAST_BIT) rx_state <= PARITY;
`else
            if (rx_bits == LAST_BIT) rx_state <= STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        PARITY: if (tick) begin
          rx_ticks <= rx_ticks + 4'd1;
          if (rx_ticks == 4'd15) begin
            rx_par_bit <= rx_sync;
            rx_state   <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          rx_ticks <= rx_ticks + 4'd1;
          if (rx_ticks == 4'd15) rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [NB_DATA-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]        rx_wr, rx_rd, rx_count;
  logic               rx_full, rx_pop, rx_write;

  assign rx_count   = rx_wr - rx_rd;
  assign rx_full    = (rx_count == FULL_CNT);
  assign o_rx_valid = (rx_count != '0);
  assign rx_pop     = o_rx_valid && i_rx_ready;
  assign rx_write   = rx_push && (!rx_full || rx_pop);
  assign o_rx_data  = o_rx_valid ? rx_mem[rx_rd[AW-1:0]] : '0;

  always_ff @(posedge i_clock) begin
    if (rx_write) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_wr          <= '0;
      rx_rd          <= '0;
      o_rx_frame_err <= 1'b0;
      o_rx_overrun   <= 1'b0;
    end else begin
      if (rx_write) rx_wr <= rx_wr + (AW+1)'(1);
      if (rx_pop)   rx_rd <= rx_rd + (AW+1)'(1);
      o_rx_frame_err <= rx_sample_stop && !rx_sync;
      o_rx_overrun   <= rx_push && rx_full && !rx_pop;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) o_rx_parity_err <= 1'b0;
    else         o_rx_parity_err <= rx_sample_stop && rx_sync && !rx_par_ok;
  end
`else
  assign o_rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// tb_uart_fifo_core: directed bench, BAUD_DIV=4 (64 cycles/bit), NB_DATA=8, FIFO_DEPTH=4.
// Parity scenario is compiled in when UART_PARITY_EN is defined.
module tb_uart_fifo_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_line;
  logic       tx, tx_ready, tx_done, rx_valid, fe, ov, pe;
  logic [7:0] rx_data;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, ov_cyc = 0;

  always #5 clk = ~clk;
  assign rx_line = loop ? tx : rx_drv;

  uart_fifo_core #(.NB_DATA(8), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx(rx_line), .o_tx(tx),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_tx_done_tick(tx_done), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_rx_ready(rx_ready), .o_rx_frame_err(fe), .o_rx_overrun(ov),
    .o_rx_parity_err(pe)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (fe) fe_cnt <= fe_cnt + 1;
    if (pe) pe_cnt <= pe_cnt + 1;
    if (ov) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, output int start);
    start = cyc; rx_drv = 1'b0; step(64);
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; step(64); end
`ifdef UART_PARITY_EN
    rx_drv = par; step(64);
`endif
    if (stop) begin rx_drv = 1'b1; step(64); end
    else begin rx_drv = 1'b0; step(48); rx_drv = 1'b1; step(16); end
  endtask

  task automatic pop_word(output logic [7:0] d, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rx_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    d = rx_data;
    if (ok) begin rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0; end
  endtask

  task automatic capture_frame(output logic [7:0] d, output logic start_ok, output logic stop_bit,
                               output int fall, output logic found);
    found = 1'b0; d = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (tx === 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    fall = cyc;
    step(32); start_ok = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin step(64); d[i] = tx; end
    step(64); stop_bit = tx;
  endtask

  task automatic test_reset();
    logic went_low;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    checks++; if ({tx_done, fe, ov, pe} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b expected 0000", {tx_done, fe, ov, pe}); end
    push_word(8'h00); push_word(8'h11); push_word(8'h22);
    step(100);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_frame_tx: got %b expected 0", tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_rst_tx: got %b expected 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b expected 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL async_rst_rx_valid: got %b expected 0", rx_valid); end
    @(negedge clk); step(2); rst = 1'b0;
    went_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx !== 1'b1) went_low = 1'b1;
      @(negedge clk);
    end
    checks++; if (went_low) begin errors++; $display("FAIL fifo_flushed: got tx activity expected idle line"); end
  endtask

  task automatic test_tx_order();
    logic [7:0] d1, d2;
    logic s1, s2, p1, p2, f1, f2;
    int fall1, fall2, done_base;
    done_base = done_cnt;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_latency_n1: got %b expected 1", tx); end
    tx_data = 8'h3C;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_latency_n2: got %b expected 0", tx); end
    capture_frame(d1, s1, p1, fall1, f1);
    capture_frame(d2, s2, p2, fall2, f2);
    checks++; if (!f1 || d1 !== 8'hA5) begin errors++; $display("FAIL tx_word0: got %h expected a5", d1); end
    checks++; if (!s1 || p1 !== 1'b1) begin errors++; $display("FAIL tx_frame0_bits: got start_ok=%b stop=%b expected 1 1", s1, p1); end
    checks++; if (!f2 || d2 !== 8'h3C) begin errors++; $display("FAIL tx_word1: got %h expected 3c", d2); end
    checks++; if (!s2 || p2 !== 1'b1) begin errors++; $display("FAIL tx_frame1_bits: got start_ok=%b stop=%b expected 1 1", s2, p2); end
    checks++; if (fall2 - fall1 < 637 || fall2 - fall1 > 644) begin errors++; $display("FAIL tx_no_gap: got %0d cycles expected 637..644", fall2 - fall1); end
    step(100);
    checks++; if (done_cnt - done_base !== 2) begin errors++; $display("FAIL tx_done_count: got %0d expected 2", done_cnt - done_base); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp [4];
    logic [7:0] d;
    logic ok;
    int fe_b, ov_b, pe_b;
    exp = '{8'h00, 8'hFF, 8'h81, 8'h7E};
    fe_b = fe_cnt; ov_b = ov_cnt; pe_b = pe_cnt;
    loop = 1'b1;
    for (int i = 0; i < 4; i++) push_word(exp[i]);
    for (int i = 0; i < 4; i++) begin
      pop_word(d, ok);
      checks++; if (!ok || d !== exp[i]) begin errors++; $display("FAIL loopback_word%0d: got %h (valid=%b) expected %h", i, d, ok, exp[i]); end
    end
    step(100);
    loop = 1'b0;
    checks++; if (fe_cnt != fe_b) begin errors++; $display("FAIL loopback_frame_err: got %0d expected 0", fe_cnt - fe_b); end
    checks++; if (ov_cnt != ov_b) begin errors++; $display("FAIL loopback_overrun: got %0d expected 0", ov_cnt - ov_b); end
    checks++; if (pe_cnt != pe_b) begin errors++; $display("FAIL loopback_parity_err: got %0d expected 0", pe_cnt - pe_b); end
  endtask

  task automatic test_overrun();
    logic [7:0] a [5];
    logic [7:0] b [5];
    logic [7:0] d;
    logic ok;
    int s, s5, s6, ov_b, delay, ep;
    a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    ov_b = ov_cnt; s5 = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(a[i], 1'b1, ^a[i], s);
      if (i == 4) s5 = s;
    end
    step(20);
    checks++; if (ov_cnt - ov_b !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt - ov_b); end
    delay = ov_cyc - s5;
    for (int i = 0; i < 4; i++) begin
      pop_word(d, ok);
      checks++; if (!ok || d !== a[i]) begin errors++; $display("FAIL overrun_word%0d: got %h expected %h", i, d, a[i]); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_dropped: got valid=%b expected 0", rx_valid); end

    ov_b = ov_cnt;
    for (int i = 0; i < 4; i++) send_frame(b[i], 1'b1, ^b[i], s);
    while ((cyc - s5) % 4 != 0) @(negedge clk);
    ep = cyc + delay;
    fork
      send_frame(b[4], 1'b1, ^b[4], s6);
      begin
        for (int i = 0; i < 3000; i++) begin
          if (cyc == ep - 1) break;
          @(negedge clk);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    step(20);
    checks++; if (ov_cnt != ov_b) begin errors++; $display("FAIL push_pop_overrun: got %0d expected 0", ov_cnt - ov_b); end
    for (int i = 1; i < 5; i++) begin
      pop_word(d, ok);
      checks++; if (!ok || d !== b[i]) begin errors++; $display("FAIL push_pop_word%0d: got %h expected %h", i, d, b[i]); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL push_pop_empty: got valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_errors();
    int fe_b, pe_b, s;
    fe_b = fe_cnt; pe_b = pe_cnt;
    rx_drv = 1'b0; step(4); rx_drv = 1'b1; step(200);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_word: got valid=%b expected 0", rx_valid); end
    checks++; if (fe_cnt != fe_b) begin errors++; $display("FAIL glitch_flag: got %0d expected 0", fe_cnt - fe_b); end
    send_frame(8'h5A, 1'b0, ^8'h5A, s);
    step(100);
    checks++; if (fe_cnt - fe_b !== 1) begin errors++; $display("FAIL frame_err_pulse: got %0d expected 1", fe_cnt - fe_b); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_word: got valid=%b expected 0", rx_valid); end
    checks++; if (pe_cnt != pe_b) begin errors++; $display("FAIL frame_err_parity: got %0d expected 0", pe_cnt - pe_b); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int fe_b, pe_b, s;
    fe_b = fe_cnt; pe_b = pe_cnt;
    send_frame(8'h01, 1'b1, 1'b0, s);
    step(50);
    checks++; if (pe_cnt - pe_b !== 1) begin errors++; $display("FAIL parity_err_pulse: got %0d expected 1", pe_cnt - pe_b); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_err_word: got valid=%b expected 0", rx_valid); end
    checks++; if (fe_cnt != fe_b) begin errors++; $display("FAIL parity_frame_err: got %0d expected 0", fe_cnt - fe_b); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    step(5);
    rst = 1'b0;
    step(2);
    test_reset();
    test_tx_order();
    test_loopback();
    test_overrun();
    test_errors();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
